// File: rtl/fifo8_sched.sv
// fifo8_sched: arbitrates two writers, one reader and flush onto a Fifo8, one operation per three cycles
module fifo8_sched #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req0,
    input  logic       wr_req1,
    input  logic [7:0] wr_data0,
    input  logic [7:0] wr_data1,
    output logic       wr_ack0,
    output logic       wr_ack1,
    input  logic       rd_req,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       flush,
    output logic       fifo_rst,
    output logic       fifo_writeEn,
    output logic       fifo_readEn,
    output logic [7:0] fifo_data,
    input  logic [4:0] fifo_count,
    input  logic [7:0] fifo_readData
);
    typedef enum logic [2:0] {IDLE, WR, RD, FLUSH, SETTLE} state_t;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);
    state_t state, state_n;
    logic rr_last, rr_last_n, rw_tok, rw_tok_n, flush_pend, flush_pend_n, was_rd;
    logic wr_elig, rd_elig, win, rd_done;

    // next state and arbitration; count is only trusted in IDLE, where every earlier op has landed
    always_comb begin
        wr_elig = (wr_req0 | wr_req1) && fifo_count < DEPTH_C;
        rd_elig = rd_req && fifo_count != 5'd0;
        win = (wr_req0 && wr_req1) ? ~rr_last : wr_req1;
        rd_done = state == SETTLE && was_rd;
        state_n = state;
        rr_last_n = rr_last;
        rw_tok_n = rw_tok;
        flush_pend_n = flush_pend | flush;
        case (state)
            IDLE: begin
                if (flush | flush_pend) begin
                    state_n = FLUSH;
                    flush_pend_n = 1'b0;
                end else if (wr_elig && (!rd_elig || rw_tok)) begin
                    state_n = WR;
                    rr_last_n = win;
                    rw_tok_n = 1'b0;
                end else if (rd_elig) begin
                    state_n = RD;
                    rw_tok_n = 1'b1;
                end
            end
            WR, RD, FLUSH: state_n = SETTLE;
            default: state_n = IDLE;
        endcase
    end

    // state plus registered outputs, which track the state being entered so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FLUSH;
            rr_last <= 1'b1;
            rw_tok <= 1'b0;
            flush_pend <= 1'b0;
            was_rd <= 1'b0;
            fifo_rst <= 1'b1;
            fifo_writeEn <= 1'b0;
            fifo_readEn <= 1'b0;
            fifo_data <= '0;
            wr_ack0 <= 1'b0;
            wr_ack1 <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            state <= state_n;
            rr_last <= rr_last_n;
            rw_tok <= rw_tok_n;
            flush_pend <= flush_pend_n;
            was_rd <= state == RD;
            fifo_rst <= state_n == FLUSH;
            fifo_writeEn <= state_n == WR;
            fifo_readEn <= state_n == RD;
            fifo_data <= state_n == WR ? (win ? wr_data1 : wr_data0) : fifo_data;
            wr_ack0 <= state_n == WR && !win;
            wr_ack1 <= state_n == WR && win;
            rd_valid <= rd_done;
            rd_data <= rd_done ? fifo_readData : rd_data;
        end
    end
endmodule

// File: doc/fifo8_sched.md
FIFO8_SCHED -- requirements
Module: fifo8_sched

Interface
REQ-001 Parameter: DEPTH, default 16, FIFO occupancy at which writes are blocked.
REQ-002 Reset: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: wr_req0 / wr_req1  input  1 each  writer N requests a push; held high until wr_ackN.
REQ-006 Port: wr_data0 / wr_data1  input  8 each  writer N data; held stable until wr_ackN.
REQ-007 Port: wr_ack0 / wr_ack1  output  1 each  one-cycle pulse; writer N's word is being pushed.
REQ-008 Port: rd_req  input  1  consumer requests a pop; held high until rd_valid.
REQ-009 Port: rd_valid  output  1  one-cycle pulse; rd_data holds the popped word.
REQ-010 Port: rd_data  output  8  popped word.
REQ-011 Port: flush  input  1  request to clear the FIFO.
REQ-012 Port: fifo_rst / fifo_writeEn / fifo_readEn  output  1 each  drive the Fifo8 rst, writeEn and readEn inputs.
REQ-013 Port: fifo_data  output  8  drives the Fifo8 data input.
REQ-014 Port: fifo_count  input  5  Fifo8 FIFOCount.
REQ-015 Port: fifo_readData  input  8  Fifo8 readData.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have the states IDLE, WR, RD, FLUSH and SETTLE.
REQ-018 In IDLE, the next state SHALL be chosen in this priority order:
  - flush=1 -> FLUSH.
  - Both write-eligible and read-eligible -> the one selected by rw_tok.
  - Write-eligible only -> WR.
  - Read-eligible only -> RD.
  - Otherwise -> remain in IDLE.
REQ-019 Write-eligible SHALL mean (wr_req0|wr_req1) and fifo_count<DEPTH; read-eligible SHALL mean rd_req and fifo_count!=0.
REQ-020 rw_tok SHALL select read when 0 and write when 1; it SHALL be set to 0 after any WR and to 1 after any RD.
REQ-021 Writer selection SHALL be round-robin: if only one writer requests, it wins; if both request, the writer other than rr_last wins; rr_last SHALL be updated to the winner.
REQ-022 On the IDLE->WR transition, fifo_data SHALL load the winner's data.
REQ-023 In WR (exactly one cycle), fifo_writeEn=1 and the winner's wr_ackN=1; next state SHALL be SETTLE.
REQ-024 In RD (exactly one cycle), fifo_readEn=1; next state SHALL be SETTLE.
REQ-025 In FLUSH (exactly one cycle), fifo_rst=1; next state SHALL be SETTLE.
REQ-026 SETTLE SHALL last one cycle, then return to IDLE; if it follows RD, rd_data SHALL capture fifo_readData and rd_valid SHALL pulse in the first IDLE cycle.
REQ-027 fifo_writeEn and fifo_readEn SHALL never be high in the same cycle, because Fifo8 loses the write on a simultaneous read and write.
REQ-028 Latency SHALL be: decision in IDLE at cycle t; WR/RD/FLUSH at t+1; SETTLE at t+2; rd_valid at t+3; next decision at t+3. Peak throughput is one operation per 3 cycles.
REQ-029 fifo_count SHALL be sampled only in IDLE, by which point it reflects every prior operation, so no occupancy shadow is required.
REQ-030 Full (fifo_count==DEPTH) SHALL block writes only; reads and flush SHALL proceed.
REQ-031 Empty (fifo_count==0) SHALL block reads only; rd_req SHALL remain pending without error.
REQ-032 A requester dropping its req before its ack SHALL simply be skipped at the next IDLE decision.
REQ-033 flush in a non-IDLE state SHALL be honoured at the next IDLE and SHALL NOT abort the operation in flight.

Reset
REQ-034 While rst=1: state=FLUSH, fifo_rst=1, fifo_writeEn=0, fifo_readEn=0, fifo_data=0, wr_ack0=0, wr_ack1=0, rd_valid=0, rd_data=0, rr_last=1 (writer 0 wins first), rw_tok=0.
REQ-035 After rst deasserts, the block SHALL run FLUSH then SETTLE, so that Fifo8 is synchronously cleared before the first IDLE decision.
REQ-036 rst asserted mid-operation SHALL abort immediately to the reset values, with no pending ack or rd_valid emitted.

Verification
REQ-037 Post-reset: release rst -> fifo_rst high 1 cycle, IDLE by the 3rd cycle, no enables asserted.
REQ-038 Single write: wr_req0=1, wr_data0=8'hA5 at count 0 -> WR 1 cycle later with fifo_data=A5, wr_ack0 pulse; fifo_count=1 two cycles after the decision.
REQ-039 Contention: wr_req0, wr_req1 and rd_req held, FIFO pre-filled with 2 words -> order RD, WR(0), RD, WR(1); enables never overlap.
REQ-040 Full: 16 words stored, wr_req1 held -> no WR issued; rd_req pulse -> RD, then WR(1) on the next decision.
REQ-041 Empty read: count 0, rd_req held 10 cycles -> no readEn; after one write of 8'h3C -> RD, rd_valid with rd_data=3C at decision+3.
REQ-042 Flush/reset: flush during WR -> write completes, then FLUSH, count 0; rst pulse during RD -> no rd_valid, outputs at reset values.
